// File: rtl/rsv_param.sv
// -----------------------------------------------------------------------------
// rsv_param -- parametrised reservation station for the Kathryn-I OoO core.
//
// Buffers up to DEPTH decoded instructions between rename and one execution
// unit. Each entry holds an opaque opcode payload, its destination ROB tag and
// two source operands. Sources that are not ready snoop CDB_N result-broadcast
// channels by ROB tag and capture the broadcast value; when several channels
// match in the same cycle the lowest-numbered channel wins. Among fully ready
// entries the oldest (by acceptance order) is moved into a registered issue
// port with valid/ready handshaking.
//
// Optional feature macro: RSV_ISSUE_BYPASS_EN
//   When defined, an instruction that is fully ready at acceptance (including
//   through same-cycle CDB capture) loads the issue register directly on its
//   acceptance edge, provided no stored entry is ready and the register is
//   loadable. Such an instruction never occupies an entry.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   flush             synchronous squash of all entries and the issue register
//   in_valid/in_ready accept handshake (in_ready is combinational)
//   in_op, in_tag     opcode payload and destination ROB tag
//   in_sN_rdy/tag/val source N readiness, producer tag, value
//   cdb_valid/tag/data CDB_N broadcast channels, channel k at slice k
//   out_valid/out_ready issue handshake; out_op/out_tag/out_s1/out_s2 payload
//   occupancy         number of valid entries
// -----------------------------------------------------------------------------
module rsv_param #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32,
    parameter int OP_W   = 8,
    parameter int CDB_N  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [OP_W-1:0]             in_op,
    input  logic [TAG_W-1:0]            in_tag,
    input  logic                        in_s1_rdy,
    input  logic                        in_s2_rdy,
    input  logic [TAG_W-1:0]            in_s1_tag,
    input  logic [TAG_W-1:0]            in_s2_tag,
    input  logic [DATA_W-1:0]           in_s1_val,
    input  logic [DATA_W-1:0]           in_s2_val,
    input  logic [CDB_N-1:0]            cdb_valid,
    input  logic [CDB_N*TAG_W-1:0]      cdb_tag,
    input  logic [CDB_N*DATA_W-1:0]     cdb_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OP_W-1:0]             out_op,
    output logic [TAG_W-1:0]            out_tag,
    output logic [DATA_W-1:0]           out_s1,
    output logic [DATA_W-1:0]           out_s2,
    output logic [$clog2(DEPTH+1)-1:0]  occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

    // Returns {hit, data} for the lowest-numbered valid channel carrying tag.
    function automatic logic [DATA_W:0] cdb_lookup(
        input logic [TAG_W-1:0]        want_tag,
        input logic [CDB_N-1:0]        bus_valid,
        input logic [CDB_N*TAG_W-1:0]  bus_tag,
        input logic [CDB_N*DATA_W-1:0] bus_data
    );
        logic [DATA_W:0] res;
        logic            hit;
        res = '0;
        // Scan from the highest channel down so the lowest match overwrites last.
        for (int k = CDB_N - 1; k >= 0; k--) begin
            hit = bus_valid[k] && (bus_tag[k*TAG_W +: TAG_W] == want_tag);
            res = hit ? {1'b1, bus_data[k*DATA_W +: DATA_W]} : res;
        end
        return res;
    endfunction

    // Entry storage
    logic [DEPTH-1:0]  valid_r;
    logic [DEPTH-1:0]  s1_rdy_r;
    logic [DEPTH-1:0]  s2_rdy_r;
    logic [OP_W-1:0]   op_r     [DEPTH];
    logic [TAG_W-1:0]  tag_r    [DEPTH];
    logic [TAG_W-1:0]  s1_tag_r [DEPTH];
    logic [TAG_W-1:0]  s2_tag_r [DEPTH];
    logic [DATA_W-1:0] s1_val_r [DEPTH];
    logic [DATA_W-1:0] s2_val_r [DEPTH];
    // age_r[i][j] = 1 means entry j was accepted before entry i
    logic [DEPTH-1:0]  age_r    [DEPTH];
    logic [OCC_W-1:0]  occ_r;

    // Issue register
    logic              out_valid_r;
    logic [OP_W-1:0]   out_op_r;
    logic [TAG_W-1:0]  out_tag_r;
    logic [DATA_W-1:0] out_s1_r;
    logic [DATA_W-1:0] out_s2_r;

    // Combinational datapath
    logic [DATA_W:0]   in_s1_lk_s;
    logic [DATA_W:0]   in_s2_lk_s;
    logic              in_s1_rdy_s;
    logic              in_s2_rdy_s;
    logic [DATA_W-1:0] in_s1_val_s;
    logic [DATA_W-1:0] in_s2_val_s;
    logic [DATA_W:0]   ent_s1_lk_s [DEPTH];
    logic [DATA_W:0]   ent_s2_lk_s [DEPTH];
    logic [DEPTH-1:0]  ent_rdy_s;
    logic [DEPTH-1:0]  grant_s;
    logic              cand_s;
    logic [OP_W-1:0]   sel_op_s;
    logic [TAG_W-1:0]  sel_tag_s;
    logic [DATA_W-1:0] sel_s1_s;
    logic [DATA_W-1:0] sel_s2_s;
    logic              in_ready_s;
    logic              in_fire_s;
    logic              load_en_s;
    logic              issue_s;
    logic              bypass_s;
    logic              store_s;
    logic [DEPTH-1:0]  free_vec_s;
    logic [DEPTH-1:0]  free_onehot_s;
    logic [DEPTH-1:0]  alloc_s;
    logic [DEPTH-1:0]  issued_s;
    logic [OCC_W-1:0]  occ_next_s;

    // Resolve the incoming instruction's sources, including same-cycle CDB capture.
    always_comb begin
        in_s1_lk_s  = cdb_lookup(in_s1_tag, cdb_valid, cdb_tag, cdb_data);
        in_s2_lk_s  = cdb_lookup(in_s2_tag, cdb_valid, cdb_tag, cdb_data);
        in_s1_rdy_s = in_s1_rdy || in_s1_lk_s[DATA_W];
        in_s2_rdy_s = in_s2_rdy || in_s2_lk_s[DATA_W];
        in_s1_val_s = in_s1_rdy ? in_s1_val : in_s1_lk_s[DATA_W-1:0];
        in_s2_val_s = in_s2_rdy ? in_s2_val : in_s2_lk_s[DATA_W-1:0];
    end

    // Per-entry CDB tag match for wakeup of stored sources.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_s1_lk_s[i] = cdb_lookup(s1_tag_r[i], cdb_valid, cdb_tag, cdb_data);
            ent_s2_lk_s[i] = cdb_lookup(s2_tag_r[i], cdb_valid, cdb_tag, cdb_data);
        end
    end

    // Oldest-ready select: an entry wins when no older entry is also ready.
    always_comb begin
        ent_rdy_s = valid_r & s1_rdy_r & s2_rdy_r;
        grant_s   = '0;
        sel_op_s  = '0;
        sel_tag_s = '0;
        sel_s1_s  = '0;
        sel_s2_s  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant_s[i] = ent_rdy_s[i] && ((ent_rdy_s & age_r[i]) == '0);
            sel_op_s   = sel_op_s  | (op_r[i]     & {OP_W{grant_s[i]}});
            sel_tag_s  = sel_tag_s | (tag_r[i]    & {TAG_W{grant_s[i]}});
            sel_s1_s   = sel_s1_s  | (s1_val_r[i] & {DATA_W{grant_s[i]}});
            sel_s2_s   = sel_s2_s  | (s2_val_r[i] & {DATA_W{grant_s[i]}});
        end
        cand_s = |ent_rdy_s;
    end

    // Handshake control: accept, issue, optional bypass, allocation, occupancy.
    always_comb begin
        // A slot freed by a same-cycle issue is deliberately not counted.
        in_ready_s = !rst && !flush && (occ_r < DEPTH_C);
        in_fire_s  = in_valid && in_ready_s;
        load_en_s  = !flush && (!out_valid_r || out_ready);
        issue_s    = load_en_s && cand_s;
`ifdef RSV_ISSUE_BYPASS_EN
        // Stored ready entries always win over the bypass.
        bypass_s   = in_fire_s && in_s1_rdy_s && in_s2_rdy_s && !cand_s && load_en_s;
`else
        bypass_s   = 1'b0;
`endif
        store_s       = in_fire_s && !bypass_s;
        free_vec_s    = ~valid_r;
        // Lowest-index free slot as a one-hot vector.
        free_onehot_s = free_vec_s & (~free_vec_s + DEPTH'(1));
        alloc_s       = store_s ? free_onehot_s : '0;
        issued_s      = issue_s ? grant_s : '0;
        occ_next_s    = occ_r + OCC_W'(store_s) - OCC_W'(issue_s);
    end

    // Entry storage: flush/issue free entries, allocation writes, wakeup captures.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r  <= '0;
            s1_rdy_r <= '0;
            s2_rdy_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_r[i]     <= '0;
                tag_r[i]    <= '0;
                s1_tag_r[i] <= '0;
                s2_tag_r[i] <= '0;
                s1_val_r[i] <= '0;
                s2_val_r[i] <= '0;
            end
        end else if (flush) begin
            valid_r <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (issued_s[i]) begin
                    valid_r[i] <= 1'b0;
                end else if (alloc_s[i]) begin
                    valid_r[i]  <= 1'b1;
                    op_r[i]     <= in_op;
                    tag_r[i]    <= in_tag;
                    s1_rdy_r[i] <= in_s1_rdy_s;
                    s2_rdy_r[i] <= in_s2_rdy_s;
                    s1_tag_r[i] <= in_s1_tag;
                    s2_tag_r[i] <= in_s2_tag;
                    s1_val_r[i] <= in_s1_val_s;
                    s2_val_r[i] <= in_s2_val_s;
                end else if (valid_r[i]) begin
                    // Once a source is ready its value is frozen.
                    if (!s1_rdy_r[i] && ent_s1_lk_s[i][DATA_W]) begin
                        s1_rdy_r[i] <= 1'b1;
                        s1_val_r[i] <= ent_s1_lk_s[i][DATA_W-1:0];
                    end
                    if (!s2_rdy_r[i] && ent_s2_lk_s[i][DATA_W]) begin
                        s2_rdy_r[i] <= 1'b1;
                        s2_val_r[i] <= ent_s2_lk_s[i][DATA_W-1:0];
                    end
                end
            end
        end
    end

    // Age matrix: a new entry is younger than everyone; others forget the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                age_r[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                age_r[i] <= age_r[i];
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                age_r[i] <= alloc_s[i] ? ~free_onehot_s : (age_r[i] & ~alloc_s);
            end
        end
    end

    // Occupancy counter: +accept into an entry, -issue from an entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_r <= '0;
        end else if (flush) begin
            occ_r <= '0;
        end else begin
            occ_r <= occ_next_s;
        end
    end

    // Issue register: load on free/consume, hold under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_op_r    <= '0;
            out_tag_r   <= '0;
            out_s1_r    <= '0;
            out_s2_r    <= '0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (issue_s) begin
            out_valid_r <= 1'b1;
            out_op_r    <= sel_op_s;
            out_tag_r   <= sel_tag_s;
            out_s1_r    <= sel_s1_s;
            out_s2_r    <= sel_s2_s;
        end else if (bypass_s) begin
            out_valid_r <= 1'b1;
            out_op_r    <= in_op;
            out_tag_r   <= in_tag;
            out_s1_r    <= in_s1_val_s;
            out_s2_r    <= in_s2_val_s;
        end else if (out_ready) begin
            // Consumed with nothing to replace it.
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_op    = out_op_r;
    assign out_tag   = out_tag_r;
    assign out_s1    = out_s1_r;
    assign out_s2    = out_s2_r;
    assign occupancy = occ_r;

endmodule

// File: tb/tb_rsv_param.sv
// -----------------------------------------------------------------------------
// tb_rsv_param -- self-checking bench for rsv_param.
// A reference model keeps the station as an age-ordered queue of instructions
// and predicts every issue; predicted issues go into a scoreboard queue that a
// negedge monitor pops on each out_valid/out_ready handshake. Directed
// scenarios are followed by a randomized phase with flushes and one async reset.
// -----------------------------------------------------------------------------
module tb_rsv_param;

    localparam int DEPTH  = 8;
    localparam int TAG_W  = 5;
    localparam int DATA_W = 32;
    localparam int OP_W   = 8;
    localparam int CDB_N  = 2;
    localparam int OCC_W  = $clog2(DEPTH + 1);
`ifdef RSV_ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      flush = 1'b0;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic [OP_W-1:0]           in_op = '0;
    logic [TAG_W-1:0]          in_tag = '0;
    logic                      in_s1_rdy = 1'b0;
    logic                      in_s2_rdy = 1'b0;
    logic [TAG_W-1:0]          in_s1_tag = '0;
    logic [TAG_W-1:0]          in_s2_tag = '0;
    logic [DATA_W-1:0]         in_s1_val = '0;
    logic [DATA_W-1:0]         in_s2_val = '0;
    logic [CDB_N-1:0]          cdb_valid = '0;
    logic [CDB_N*TAG_W-1:0]    cdb_tag = '0;
    logic [CDB_N*DATA_W-1:0]   cdb_data = '0;
    logic                      out_valid;
    logic                      out_ready = 1'b0;
    logic [OP_W-1:0]           out_op;
    logic [TAG_W-1:0]          out_tag;
    logic [DATA_W-1:0]         out_s1;
    logic [DATA_W-1:0]         out_s2;
    logic [OCC_W-1:0]          occupancy;

    rsv_param #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W), .CDB_N(CDB_N)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_tag(in_tag),
        .in_s1_rdy(in_s1_rdy), .in_s2_rdy(in_s2_rdy),
        .in_s1_tag(in_s1_tag), .in_s2_tag(in_s2_tag),
        .in_s1_val(in_s1_val), .in_s2_val(in_s2_val),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_tag(out_tag),
        .out_s1(out_s1), .out_s2(out_s2), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  tag;
        bit                r1;
        logic [TAG_W-1:0]  t1;
        logic [DATA_W-1:0] v1;
        bit                r2;
        logic [TAG_W-1:0]  t2;
        logic [DATA_W-1:0] v2;
    } ent_t;

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] s1;
        logic [DATA_W-1:0] s2;
    } iss_t;

    ent_t ent_q[$];           // model station contents, oldest first
    iss_t exp_q[$];           // scoreboard of predicted issues
    bit   m_valid = 1'b0;     // model issue register valid

    logic [TAG_W-1:0]  seen_tag[$];
    logic [DATA_W-1:0] seen_s1[$];
    logic [DATA_W-1:0] seen_s2[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // First valid CDB channel (lowest index) carrying tag t.
    function automatic bit cdb_hit(input logic [TAG_W-1:0] t, output logic [DATA_W-1:0] d);
        d = '0;
        for (int k = 0; k < CDB_N; k++) begin
            if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == t) begin
                d = cdb_data[k*DATA_W +: DATA_W];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_issue(input ent_t e);
        iss_t x;
        x.op = e.op; x.tag = e.tag; x.s1 = e.v1; x.s2 = e.v2;
        m_valid = 1'b1;
        exp_q.push_back(x);
    endtask

    task automatic model_step();
        ent_t nw;
        int sel;
        bit fire, load, byp;
        logic [DATA_W-1:0] d;
        if (flush) begin
            ent_q.delete();
            exp_q.delete();
            m_valid = 1'b0;
            return;
        end
        fire = in_valid && (ent_q.size() < DEPTH);
        load = !m_valid || out_ready;
        sel = -1;
        foreach (ent_q[i]) begin
            if (sel < 0 && ent_q[i].r1 && ent_q[i].r2) sel = i;
        end
        nw.op = in_op; nw.tag = in_tag;
        nw.r1 = in_s1_rdy; nw.t1 = in_s1_tag; nw.v1 = in_s1_val;
        nw.r2 = in_s2_rdy; nw.t2 = in_s2_tag; nw.v2 = in_s2_val;
        if (!nw.r1 && cdb_hit(nw.t1, d)) begin nw.r1 = 1'b1; nw.v1 = d; end
        if (!nw.r2 && cdb_hit(nw.t2, d)) begin nw.r2 = 1'b1; nw.v2 = d; end
        byp = BYP && fire && nw.r1 && nw.r2 && (sel < 0) && load;
        if (load && sel >= 0) begin
            model_issue(ent_q[sel]);
            ent_q.delete(sel);
        end else if (byp) begin
            model_issue(nw);
        end else if (load) begin
            m_valid = 1'b0;
        end
        foreach (ent_q[i]) begin
            if (!ent_q[i].r1 && cdb_hit(ent_q[i].t1, d)) begin ent_q[i].r1 = 1'b1; ent_q[i].v1 = d; end
            if (!ent_q[i].r2 && cdb_hit(ent_q[i].t2, d)) begin ent_q[i].r2 = 1'b1; ent_q[i].v2 = d; end
        end
        if (fire && !byp) ent_q.push_back(nw);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_q.delete();
            exp_q.delete();
            m_valid = 1'b0;
        end else begin
            model_step();
        end
    end

    // Monitor: compare status every cycle, pop scoreboard on handshakes.
    always @(negedge clk) begin
        chk("in_ready", in_ready, (!rst && !flush && ent_q.size() < DEPTH));
        chk("occupancy", occupancy, ent_q.size());
        chk("out_valid", out_valid, m_valid);
        if (out_valid && !rst) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_issue", 1, 0);
            end else begin
                chk("out_op", out_op, exp_q[0].op);
                chk("out_tag", out_tag, exp_q[0].tag);
                chk("out_s1", out_s1, exp_q[0].s1);
                chk("out_s2", out_s2, exp_q[0].s2);
                if (out_ready && !flush) begin
                    seen_tag.push_back(out_tag);
                    seen_s1.push_back(out_s1);
                    seen_s2.push_back(out_s2);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        in_valid = 1'b0; flush = 1'b0; cdb_valid = '0;
    endtask

    task automatic offer(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] tag,
                         input logic r1, input logic [TAG_W-1:0] t1, input logic [DATA_W-1:0] v1,
                         input logic r2, input logic [TAG_W-1:0] t2, input logic [DATA_W-1:0] v2);
        in_valid = 1'b1; in_op = op; in_tag = tag;
        in_s1_rdy = r1; in_s1_tag = t1; in_s1_val = v1;
        in_s2_rdy = r2; in_s2_tag = t2; in_s2_val = v2;
    endtask

    task automatic drive_cdb(input int ch, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        cdb_valid[ch] = 1'b1;
        cdb_tag[ch*TAG_W +: TAG_W] = t;
        cdb_data[ch*DATA_W +: DATA_W] = d;
    endtask

    task automatic clean();
        quiet();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        seen_tag.delete(); seen_s1.delete(); seen_s2.delete();
    endtask

    task automatic wait_seen(input int n, input int budget);
        int c = 0;
        while (seen_tag.size() < n && c < budget) begin
            cyc();
            c++;
        end
        chk("issue_count", seen_tag.size(), n);
    endtask

    initial begin
        // Reset state
        cyc(); cyc();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_op", out_op, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_out_s1", out_s1, 0);
        chk("rst_out_s2", out_s2, 0);
        chk("rst_occupancy", occupancy, 0);
        rst = 1'b0;
        cyc();

        // Ready instruction latency
        out_ready = 1'b1;
        offer(8'h33, 5'd3, 1'b1, 5'd0, 32'd5, 1'b1, 5'd0, 32'd7);
        cyc();
        quiet();
        if (BYP) begin
            chk("lat_valid", out_valid, 1);
            chk("lat_occ", occupancy, 0);
        end else begin
            chk("lat_valid_early", out_valid, 0);
            chk("lat_occ_early", occupancy, 1);
            cyc();
        end
        chk("lat_valid", out_valid, 1);
        chk("lat_tag", out_tag, 3);
        chk("lat_s1", out_s1, 5);
        chk("lat_s2", out_s2, 7);
        chk("lat_occ_after", occupancy, 0);
        cyc();
        chk("lat_drained", out_valid, 0);

        // Older waiting entry is overtaken by a younger ready one
        clean();
        out_ready = 1'b1;
        offer(8'h01, 5'd1, 1'b0, 5'd9, 32'h0, 1'b1, 5'd0, 32'h2);
        cyc();
        offer(8'h02, 5'd2, 1'b1, 5'd0, 32'h3, 1'b1, 5'd0, 32'h4);
        cyc();
        quiet();
        drive_cdb(1, 5'd9, 32'hAA);
        cyc();
        quiet();
        wait_seen(2, 20);
        if (seen_tag.size() >= 2) begin
            chk("ooo_first", seen_tag[0], 2);
            chk("ooo_second", seen_tag[1], 1);
            chk("ooo_wake_s1", seen_s1[1], 32'hAA);
        end

        // Fill the station, then wake all with two matching channels
        clean();
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            offer(OP_W'(i), TAG_W'(10 + i), 1'b0, 5'd4, 32'h0, 1'b1, 5'd0, DATA_W'(32'h100 + i));
            cyc();
        end
        quiet();
        chk("full_occ", occupancy, DEPTH);
        chk("full_in_ready", in_ready, 0);
        drive_cdb(0, 5'd4, 32'h1111);
        drive_cdb(1, 5'd4, 32'h2222);
        cyc();
        quiet();
        wait_seen(DEPTH, 40);
        for (int i = 0; i < DEPTH && i < seen_tag.size(); i++) begin
            chk("full_order", seen_tag[i], 10 + i);
            chk("full_ch0_wins", seen_s1[i], 32'h1111);
        end

        // Backpressure holds the issue register stable
        clean();
        out_ready = 1'b0;
        offer(8'h21, 5'd21, 1'b1, 5'd0, 32'h21, 1'b1, 5'd0, 32'h121);
        cyc();
        offer(8'h22, 5'd22, 1'b1, 5'd0, 32'h22, 1'b1, 5'd0, 32'h122);
        cyc();
        quiet();
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stall_valid", out_valid, 1);
            chk("stall_tag", out_tag, 21);
        end
        out_ready = 1'b1;
        cyc();
        chk("release_valid", out_valid, 1);
        chk("release_tag", out_tag, 22);
        wait_seen(2, 10);

        // Broadcast coinciding with acceptance is captured
        clean();
        out_ready = 1'b1;
        offer(8'h23, 5'd23, 1'b1, 5'd0, 32'h10, 1'b0, 5'd6, 32'h99);
        drive_cdb(0, 5'd6, 32'h55);
        cyc();
        quiet();
        wait_seen(1, 10);
        if (seen_tag.size() >= 1) begin
            chk("same_cycle_tag", seen_tag[0], 23);
            chk("same_cycle_s2", seen_s2[0], 32'h55);
        end

        // Flush with live entries, a held output and an offered instruction
        clean();
        out_ready = 1'b0;
        offer(8'h24, 5'd24, 1'b1, 5'd0, 32'h1, 1'b1, 5'd0, 32'h2);
        cyc();
        for (int i = 0; i < 4; i++) begin
            offer(OP_W'(i), TAG_W'(25 + i), 1'b0, 5'd20, 32'h0, 1'b1, 5'd0, 32'h5);
            cyc();
        end
        quiet();
        cyc();
        chk("preflush_occ", occupancy, 4);
        chk("preflush_valid", out_valid, 1);
        offer(8'h77, 5'd30, 1'b1, 5'd0, 32'h7, 1'b1, 5'd0, 32'h8);
        flush = 1'b1;
        out_ready = 1'b1;
        cyc();
        chk("flush_occ", occupancy, 0);
        chk("flush_valid", out_valid, 0);
        quiet();
        cyc();
        chk("flush_not_stored", occupancy, 0);
        chk("flush_no_issue", out_valid, 0);

        // Randomized traffic with rare flushes and one asynchronous reset
        clean();
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom % 10) < 6;
            in_op     = OP_W'($urandom);
            in_tag    = TAG_W'($urandom);
            in_s1_rdy = $urandom % 2;
            in_s2_rdy = $urandom % 2;
            in_s1_tag = TAG_W'($urandom % 8);
            in_s2_tag = TAG_W'($urandom % 8);
            in_s1_val = $urandom;
            in_s2_val = $urandom;
            for (int k = 0; k < CDB_N; k++) begin
                cdb_valid[k] = ($urandom % 3) == 0;
                cdb_tag[k*TAG_W +: TAG_W] = TAG_W'($urandom % 8);
                cdb_data[k*DATA_W +: DATA_W] = $urandom;
            end
            out_ready = ($urandom % 10) < 7;
            flush     = ($urandom % 100) == 0;
            if (n == 1500) begin
                #2 rst = 1'b1;
                cyc();
                cyc();
                rst = 1'b0;
            end
            cyc();
        end
        clean();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rsv_param.md
# rsv_param

Parametrised reservation station for the Kathryn-I out-of-order core. It buffers up to DEPTH decoded instructions and captures operands from CDB_N result-broadcast channels, tagged by ROB entry. It issues the oldest fully-ready instruction to its execution unit through a registered valid/ready port. It sits between the decoder/rename stage and one execution unit, and supersedes the fixed single-channel station.

## Interface
Parameters:
- DEPTH, 8: number of station entries; integer ≥ 2.
- TAG_W, 5: ROB tag width.
- DATA_W, 32: operand width.
- OP_W, 8: decoded-opcode payload width, carried opaquely.
- CDB_N, 2: number of result-broadcast channels.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous squash of all entries and the output register.
- in_valid  in  1  decoded instruction offered.
- in_ready  out  1  station can accept this cycle.
- in_op  in  OP_W  opcode payload.
- in_tag  in  TAG_W  destination ROB tag.
- in_s1_rdy, in_s2_rdy  in  1 each  source operand already valid.
- in_s1_tag, in_s2_tag  in  TAG_W each  producer tag when the source is not ready.
- in_s1_val, in_s2_val  in  DATA_W each  operand value when the source is ready.
- cdb_valid  in  CDB_N  per-channel broadcast valid.
- cdb_tag  in  CDB_N*TAG_W  channel k occupies bits [k*TAG_W +: TAG_W].
- cdb_data  in  CDB_N*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- out_valid  out  1  issue register holds an instruction.
- out_ready  in  1  execution unit accepts.
- out_op, out_tag  out  OP_W, TAG_W  issued payload.
- out_s1, out_s2  out  DATA_W each  issued operands.
- occupancy  out  $clog2(DEPTH+1)  number of valid entries.

## Operation
- Reset: all entries invalid. out_valid=0. out_op, out_tag, out_s1 and out_s2 are 0. occupancy=0. in_ready=0 while rst is high.
- in_ready = !flush && (occupancy < DEPTH). It does not count a slot freed by a same-cycle issue.
- Accept: when in_valid && in_ready, write the instruction to any free entry and stamp it with its acceptance order.
- Wakeup: each cycle, every valid entry source with rdy=0 compares its tag against all cdb_tag[k] where cdb_valid[k]=1. On a match, it captures cdb_data[k] and sets rdy=1.
  - If more than one channel matches, the lowest k wins.
  - The entry being accepted is also checked against the same-cycle CDB, so a broadcast coinciding with acceptance is never lost.
- Select: an entry is ready when s1_rdy && s2_rdy. Among ready entries, pick the oldest by acceptance order.
- Issue register:
  - It loads when (!out_valid || out_ready) and a selected candidate exists. The chosen entry is freed on the same edge.
  - If out_valid && !out_ready, the register holds all outputs stable.
  - out_valid drops after a consume only if no candidate exists.
- Occupancy is updated as +accept −issue in the same cycle, so simultaneous accept and issue leave it unchanged.
- Flush:
  - On the next edge, all entries are invalidated, out_valid=0 and occupancy=0.
  - Flush has priority over accept, wakeup and issue.
  - A flush coinciding with out_ready does not issue.
- Operand values in an entry are never modified after rdy=1.

## Timing
- Accept-to-issue latency (without bypass): accept at edge E, then the entry is visible; out_valid=1 after edge E+1 at the earliest.
- CDB wakeup at edge W: the entry becomes selectable in the cycle after W, so out_valid follows after edge W+1.
- Throughput: one issue per cycle when out_ready is held high and ready entries exist.
- A full station (occupancy=DEPTH) drops in_ready in the same cycle. in_ready returns the cycle after an issue or flush edge.
- Asynchronous rst asserted mid-operation clears all state immediately; no instruction is issued after it.

## Configuration
- RSV_ISSUE_BYPASS_EN defined: an accepted instruction that is fully ready at entry (including through same-cycle CDB capture) may load the issue register on its acceptance edge E. Conditions:
  - No stored entry is ready.
  - The issue register is loadable.
  - It then occupies no entry, and occupancy is not incremented. Latency is 1 cycle.
- Not defined: every instruction passes through an entry, with a minimum latency of 2 cycles.
- Stored ready entries always take priority over the bypass.

## Test plan
- Reset, then accept tag 3 with both sources ready (5, 7) and out_ready=1: out_valid=1, out_tag=3, out_s1=5, out_s2=7 two edges after acceptance (one with RSV_ISSUE_BYPASS_EN); occupancy returns to 0.
- Accept tag 1 waiting on src tag 9, then tag 2 fully ready; broadcast tag 9 = 0xAA on channel 1: tag 2 issues first, then tag 1 with out_s1=0xAA.
- Fill DEPTH=8 entries waiting on tag 4: in_ready=0 and occupancy=8. Then broadcast tag 4 on channels 0 and 1 simultaneously with different data: all eight entries capture channel-0 data and issue in acceptance order.
- Hold out_ready=0 with out_valid=1 for 5 cycles: outputs stay stable. Release it: the next-oldest instruction issues the following cycle.
- Broadcast tag 6 = 0x55 in the same cycle as accepting an entry whose src2 waits on tag 6: the entry captures 0x55 and issues without a further broadcast.
- Assert flush with 4 valid entries, out_valid=1 and in_valid=1: after the edge, occupancy=0 and out_valid=0, and the offered instruction is not stored.
